width_conv_fifo: RTL and testbench

WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

---
 rtl/wcf_pkg.sv | 42 ++++
 rtl/wcf_ram.sv | 38 +++
 rtl/width_conv_fifo.sv | 141 ++++++++++++++
 tb/tb_width_conv_fifo.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wcf_pkg.sv
// rtl/wcf_pkg.sv - shared helpers and types for the width-converting FIFO
// Contents: wcf_clog2, wcf_is_pow2, wcf_min, wcf_cfg_ok (configuration legality),
//           wcf_ptr_t (narrow-word pointer type) and wcf_ptr_adv (pointer step).
package wcf_pkg;

  // Largest supported RAM address width; pointers carry one extra wrap bit.
  localparam int WCF_MAX_AW = 15;

  typedef logic [WCF_MAX_AW:0] wcf_ptr_t;

  function automatic int wcf_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit wcf_is_pow2(input int v);
    return (v > 0) && ((1 << wcf_clog2(v)) == v);
  endfunction

  function automatic int wcf_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Both widths powers of two and each side's ratio fits in the RAM.
  function automatic bit wcf_cfg_ok(input int dwi, input int dwo, input int aw);
    int n;
    n = wcf_min(dwi, dwo);
    if (aw < 1 || aw > WCF_MAX_AW) return 1'b0;
    if (!wcf_is_pow2(dwi) || !wcf_is_pow2(dwo)) return 1'b0;
    return ((dwi / n) <= (1 << aw)) && ((dwo / n) <= (1 << aw));
  endfunction

  // Advance a pointer; callers truncate to AW+1 bits, giving the modulo wrap.
  function automatic wcf_ptr_t wcf_ptr_adv(input wcf_ptr_t p, input int step);
    return p + wcf_ptr_t'(step);
  endfunction

endpackage

// File: rtl/wcf_ram.sv
// rtl/wcf_ram.sv - simple dual-port narrow-word RAM with multi-lane write and read
// Ports: clk_i; we_i/waddr_i/wdata_i write RI consecutive words starting at waddr_i
//        (wdata_i MSB slice to waddr_i); raddr_i/rdata_o read RO consecutive words
//        asynchronously (word at raddr_i lands in the rdata_o MSB slice). Not reset.
module wcf_ram
  import wcf_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 4,
  parameter int RI = 1,
  parameter int RO = 2
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [RI*N-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [RO*N-1:0] rdata_o
);

  logic [N-1:0] mem_q [1<<AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < RI; i++) begin
        mem_q[waddr_i + AW'(i)] <= wdata_i[(RI-1-i)*N +: N];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int j = 0; j < RO; j++) begin
      rdata_o[(RO-1-j)*N +: N] = mem_q[raddr_i + AW'(j)];
    end
  end

endmodule

// File: rtl/width_conv_fifo.sv
// rtl/width_conv_fifo.sv - single-clock FIFO converting DWI-bit writes to DWO-bit reads
// Ports: clk, rst_n (sync, active-low), flush (sync clear);
//        s_valid/s_ready/s_data write side; m_valid/m_ready/m_data read side;
//        level (narrow words in RAM, output register excluded), full, empty;
//        almost_full/almost_empty only when WIDTH_CONV_FIFO_ALMOST_EN is defined.
// Data is big-endian: the first narrow word stored is the most significant.
module width_conv_fifo
  import wcf_pkg::*;
#(
  parameter int DWI       = 8,
  parameter int DWO       = 16,
  parameter int AW        = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DWI-1:0] s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DWO-1:0] m_data,
`ifdef WIDTH_CONV_FIFO_ALMOST_EN
  output logic           almost_full,
  output logic           almost_empty,
`endif
  output logic [AW:0]    level,
  output logic           full,
  output logic           empty
);

  localparam int N     = wcf_min(DWI, DWO);
  localparam int RI    = DWI / N;
  localparam int RO    = DWO / N;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] RI_W    = (AW+1)'(RI);
  localparam logic [AW:0] RO_W    = (AW+1)'(RO);

  if (!wcf_cfg_ok(DWI, DWO, AW) || AF_THRESH < 0 || AE_THRESH < 0) begin : g_cfg_err
    $error("width_conv_fifo: unsupported DWI/DWO/AW/threshold configuration");
  end

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           m_valid_q, m_valid_d;
  logic [DWO-1:0] m_data_q, m_data_d;
  logic [DWO-1:0] ram_rdata;
  logic           space_ok;
  logic           wr;
  logic           ld;

  // Pointers carry a wrap bit, so the difference is the fill count even at 2**AW.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign space_ok = (DEPTH_W - level) >= RI_W;
  assign s_ready  = space_ok && rst_n && !flush;
  assign full     = !space_ok;
  assign empty    = (level == '0) && !m_valid_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;

  assign wr = s_valid && s_ready;
  // Refill the output register whenever it is empty or being consumed this edge.
  assign ld = rst_n && !flush && (level >= RO_W) && (!m_valid_q || m_ready);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (wr) wr_ptr_d = (AW+1)'(wcf_ptr_adv(wcf_ptr_t'(wr_ptr_q), RI));
    if (ld) begin
      rd_ptr_d  = (AW+1)'(wcf_ptr_adv(wcf_ptr_t'(rd_ptr_q), RO));
      m_valid_d = 1'b1;
      m_data_d  = ram_rdata;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

`ifdef WIDTH_CONV_FIFO_ALMOST_EN
  logic [AW:0] level_d;
  logic        almost_full_q;
  logic        almost_empty_q;

  always_comb begin
    level_d = level + (wr ? RI_W : '0) - (ld ? RO_W : '0);
    if (flush) level_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= int'(level_d) >= AF_THRESH;
      almost_empty_q <= int'(level_d) <= AE_THRESH;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  wcf_ram #(
    .N  (N),
    .AW (AW),
    .RI (RI),
    .RO (RO)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (s_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_width_conv_fifo.sv
// tb/tb_width_conv_fifo.sv - scoreboard bench for width_conv_fifo (8->16 and 32->8 instances)
module tb_width_conv_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [4:0]  level;
  logic        full, empty;

  logic        flush2 = 1'b0;
  logic        s2_valid = 1'b0;
  logic        s2_ready;
  logic [31:0] s2_data = '0;
  logic        m2_valid;
  logic        m2_ready = 1'b0;
  logic [7:0]  m2_data;
  logic [4:0]  level2;
  logic        full2, empty2;
`ifdef WIDTH_CONV_FIFO_ALMOST_EN
  logic        almost_full, almost_empty, almost_full2, almost_empty2;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  s2_exp_q[$];
  logic [7:0]  half_q;
  bit          have_half = 1'b0;
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  width_conv_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef WIDTH_CONV_FIFO_ALMOST_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .level(level), .full(full), .empty(empty)
  );

  width_conv_fifo #(.DWI(32), .DWO(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
    .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data),
`ifdef WIDTH_CONV_FIFO_ALMOST_EN
    .almost_full(almost_full2), .almost_empty(almost_empty2),
`endif
    .level(level2), .full(full2), .empty(empty2)
  );

  // Advance one clock, recording handshakes: writes push expected words,
  // accepted reads push observed words.
  task automatic tick();
    logic wr, rd, wr2;
    #1;
    wr  = s_valid && s_ready;
    rd  = m_valid && m_ready && rst_n && !flush;
    wr2 = s2_valid && s2_ready;
    if (!rst_n || flush) begin
      exp_q.delete();
      got_q.delete();
      have_half = 1'b0;
    end else begin
      if (wr) begin
        if (have_half) exp_q.push_back({half_q, s_data});
        else half_q = s_data;
        have_half = !have_half;
        wr_cnt++;
      end
      if (rd) got_q.push_back(m_data);
    end
    if (!rst_n) s2_exp_q.delete();
    else if (wr2) begin
      for (int k = 0; k < 4; k++) s2_exp_q.push_back(s2_data[31-8*k -: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL rst_m_data got %h exp 0000", m_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
`ifdef WIDTH_CONV_FIFO_ALMOST_EN
    checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      errors++; $display("FAIL rst_almost got af=%b ae=%b exp af=0 ae=1", almost_full, almost_empty);
    end
`endif
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_pair();
    logic [15:0] g, e;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA1; tick();
    s_data = 8'hB2; tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pair_early_valid got %b exp 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL pair_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== 16'hA1B2) begin errors++; $display("FAIL pair_data got %h exp a1b2", m_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL pair_level got %0d exp 0", level); end
    m_ready = 1'b1;
    for (int c = 0; c < 10 && (m_valid || level != 0); c++) tick();
    m_ready = 1'b0;
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL pair_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL pair_sb got %h exp %h", g, e); end
    end
  endtask

  task automatic test_shrink();
    logic [7:0] e;
    int c;
    m2_ready = 1'b1;
    s2_valid = 1'b1; s2_data = 32'h11223344; tick();
    s2_valid = 1'b0;
    for (c = 0; c < 5 && !m2_valid; c++) tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (m2_valid !== 1'b1) begin errors++; $display("FAIL shrink_valid%0d got %b exp 1", k, m2_valid); end
      if (s2_exp_q.size() > 0) begin
        e = s2_exp_q.pop_front();
        checks++; if (m2_data !== e) begin errors++; $display("FAIL shrink_data%0d got %h exp %h", k, m2_data, e); end
      end else begin
        checks++; errors++; $display("FAIL shrink_sb%0d got extra word %h exp none", k, m2_data);
      end
      tick();
    end
    checks++; if (m2_valid !== 1'b0) begin errors++; $display("FAIL shrink_done got %b exp 0", m2_valid); end
    m2_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [15:0] g, e;
    m_ready = 1'b0;
    wr_cnt = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 40 && wr_cnt < 18; c++) begin
      s_data = 8'(wr_cnt + 1);
      tick();
    end
    s_valid = 1'b0;
    checks++; if (wr_cnt != 18) begin errors++; $display("FAIL full_writes got %0d exp 18", wr_cnt); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b exp 0", s_ready); end
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0102) begin
      errors++; $display("FAIL full_outreg got v=%b %h exp v=1 0102", m_valid, m_data);
    end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_release got %b exp 1", s_ready); end
    checks++; if (level !== 5'd14) begin errors++; $display("FAIL full_release_level got %0d exp 14", level); end
    m_ready = 1'b1;
    for (int c = 0; c < 30 && (m_valid || level != 0); c++) tick();
    m_ready = 1'b0;
    checks++; if (got_q.size() != 9 || exp_q.size() != 9) begin
      errors++; $display("FAIL full_count got %0d exp %0d (9 words)", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL full_sb got %h exp %h", g, e); end
    end
  endtask

  task automatic test_hold_and_wrap();
    logic [15:0] g, e;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin s_data = 8'h10 + 8'(i); tick(); end
    s_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (m_valid !== 1'b1 || exp_q.size() == 0 || m_data !== exp_q[0]) begin
        errors++; $display("FAIL hold%0d got v=%b %h exp v=1 1011", i, m_valid, m_data);
      end
    end
    wr_cnt = 0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int c = 0; c < 800 && wr_cnt < 256; c++) begin
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 1'b0;
    for (int c = 0; c < 40 && (m_valid || level != 0); c++) tick();
    m_ready = 1'b0;
    checks++; if (got_q.size() != 130 || exp_q.size() != 130) begin
      errors++; $display("FAIL wrap_count got %0d exp %0d (130 words)", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL wrap_sb got %h exp %h", g, e); end
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int c = 0; c < 20 && level != 5'd6; c++) begin
      s_valid = 1'b1; s_data = 8'h60 + 8'(c); tick();
    end
    s_valid = 1'b0;
    checks++; if (level !== 5'd6) begin errors++; $display("FAIL flush_setup_level got %0d exp 6", level); end
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_s_ready got %b exp 0", s_ready); end
    tick();
    flush = 1'b0; s_valid = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid got %b exp 0", m_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
    tick(); tick();
    checks++; if (level !== 5'd0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dropped got level=%0d v=%b exp 0 0", level, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] g, e;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin s_data = 8'h70 + 8'(i); tick(); end
    s_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0 || m_data !== 16'h0) begin
      errors++; $display("FAIL midrst_out got v=%b %h exp v=0 0000", m_valid, m_data);
    end
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL midrst_level got %0d empty=%b exp 0 1", level, empty);
    end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready got %b exp 0", s_ready); end
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h5A; tick();
    s_data = 8'hC3; tick();
    s_valid = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h5AC3) begin
      errors++; $display("FAIL midrst_first got v=%b %h exp v=1 5ac3", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 10 && (m_valid || level != 0); c++) tick();
    m_ready = 1'b0;
    checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL midrst_count got %0d exp %0d (1 word)", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL midrst_sb got %h exp %h", g, e); end
    end
  endtask

`ifdef WIDTH_CONV_FIFO_ALMOST_EN
  task automatic test_almost();
    m_ready = 1'b0;
    for (int c = 0; c < 30 && level != 5'd11; c++) begin
      s_valid = 1'b1; s_data = 8'(c); tick();
    end
    s_valid = 1'b0;
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_below got %b exp 0 (level %0d)", almost_full, level); end
    s_valid = 1'b1; s_data = 8'hFF; tick();
    s_valid = 1'b0;
    checks++; if (level !== 5'd12 || almost_full !== 1'b1) begin
      errors++; $display("FAIL af_at got level=%0d af=%b exp 12 1", level, almost_full);
    end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pair();
    test_shrink();
    test_full();
    test_hold_and_wrap();
    test_flush();
    test_reset_mid();
`ifdef WIDTH_CONV_FIFO_ALMOST_EN
    test_almost();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
